sub: RTL and testbench

SUB -- requirements
Module: sub

---
 rtl/sub.sv | 67 ++++++
 tb/tb_sub.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sub.sv
// Subtractor with combinational difference/flags and a one-cycle registered copy.
// Optional sticky signed-overflow flag is built only when SUB_STICKY_OVF_EN is defined.
module sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_b,
  output logic             flag_v,
  output logic [WIDTH-1:0] out_q,
  output logic [3:0]       flags_q,
  output logic             ovf_sticky
);

  logic [WIDTH:0] diff_ext;
  logic [3:0]     flags_d;

  // The extra MSB of the zero-extended difference is the borrow out.
  assign diff_ext = {1'b0, input1} - {1'b0, input2};
  assign out      = diff_ext[WIDTH-1:0];
  assign flag_b   = diff_ext[WIDTH];
  assign flag_z   = (out == '0);
  assign flag_n   = out[WIDTH-1];
  assign flag_v   = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                    (out[WIDTH-1] != input1[WIDTH-1]);
  assign flags_d  = {flag_z, flag_n, flag_b, flag_v};

  // NOTE: reset sits in the sensitivity list so outputs clear without waiting for clk;
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      flags_q <= 4'b0000;
    end else begin
      out_q   <= out;
      flags_q <= flags_d;
    end
  end

`ifdef SUB_STICKY_OVF_EN
  logic sticky_q;
  logic sticky_d;

  // Set has priority over clear so a concurrent overflow is never lost.
  always_comb begin
    sticky_d = flag_v | (sticky_q & ~clr_sticky);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign ovf_sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_sub.sv
// Directed self-checking bench for sub (WIDTH=32); sticky expectations follow SUB_STICKY_OVF_EN.
module tb_sub;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             clr_sticky;
  logic [WIDTH-1:0] out;
  logic             flag_z, flag_n, flag_b, flag_v;
  logic [WIDTH-1:0] out_q;
  logic [3:0]       flags_q;
  logic             ovf_sticky;

  int checks   = 0;
  int failures = 0;
  logic sticky_exp = 1'b0;

  sub #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .input1     (input1),
    .input2     (input2),
    .clr_sticky (clr_sticky),
    .out        (out),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_b     (flag_b),
    .flag_v     (flag_v),
    .out_q      (out_q),
    .flags_q    (flags_q),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one vector mid-cycle, check the combinational result, clock it, check registers.
  task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic clr, input logic [WIDTH-1:0] exp_out,
                       input logic [3:0] exp_flags);
    @(negedge clk);
    input1     = a;
    input2     = b;
    clr_sticky = clr;
    #1;
    check("out", out, exp_out);
    check("flags", {flag_z, flag_n, flag_b, flag_v}, exp_flags);
    @(posedge clk);
`ifdef SUB_STICKY_OVF_EN
    sticky_exp = exp_flags[0] | (sticky_exp & ~clr);
`else
    sticky_exp = 1'b0;
`endif
    #1;
    check("out_q", out_q, exp_out);
    check("flags_q", flags_q, exp_flags);
    check("ovf_sticky", ovf_sticky, sticky_exp);
  endtask

  initial begin
    rst        = 1'b1;
    input1     = '0;
    input2     = '0;
    clr_sticky = 1'b0;
    #2;
    check("rst_out_q", out_q, 0);
    check("rst_flags_q", flags_q, 0);
    check("rst_sticky", ovf_sticky, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //        input1        input2        clr   out           {z,n,b,v}
    apply(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b1000);
    apply(32'd10,        32'd0,         1'b0, 32'h0000_000A, 4'b0000);
    apply(32'd1000,      32'd10,        1'b0, 32'h0000_03DE, 4'b0000);
    apply(32'h0300_1000, 32'h0000_FFFF, 1'b0, 32'h02FF_1001, 4'b0000);
    apply(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b0110);
    apply(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0001);
    apply(32'd10,        32'd3,         1'b0, 32'h0000_0007, 4'b0000);
    apply(32'd10,        32'd3,         1'b0, 32'h0000_0007, 4'b0000);
    apply(32'd10,        32'd3,         1'b1, 32'h0000_0007, 4'b0000);
    apply(32'h0000_0001, 32'h8000_0000, 1'b0, 32'h8000_0001, 4'b0111);
    apply(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0001);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 4'b1000);
    apply(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 4'b1000);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 4'b0001);

    // Asynchronous reset between edges with a nonzero registered value.
    apply(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0001);
    input1 = 32'd1000;
    input2 = 32'd10;
    #2;
    rst = 1'b1;
    #1;
    check("async_out_q", out_q, 0);
    check("async_flags_q", flags_q, 0);
    check("async_sticky", ovf_sticky, 0);
    check("rst_comb_out", out, 32'h0000_03DE);
    sticky_exp = 1'b0;
    @(posedge clk);
    #1;
    check("held_out_q", out_q, 0);
    @(negedge clk);
    rst = 1'b0;
    apply(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b0110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
